// File: rtl/spectrum_frame_sequencer_pkg.sv
// rtl/spectrum_frame_sequencer_pkg.sv - shared spectrum constants and sequencer state encoding
package spectrum_frame_sequencer_pkg;

   localparam int N_POINTS_DEF      = 1024;
   localparam int DATA_W_DEF        = 64;
   localparam int ADDR_W_DEF        = 10;
   localparam int ADAPT_TIMEOUT_DEF = 2048;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SCAN       = 3'd1,
      ST_DRAIN      = 3'd2,
      ST_START      = 3'd3,
      ST_ADAPT_WAIT = 3'd4,
      ST_SWAP_WAIT  = 3'd5
   } seq_state_e;

endpackage

// File: rtl/spectrum_frame_sequencer_peak_tracker.sv
// rtl/spectrum_frame_sequencer_peak_tracker.sv - unsigned running maximum with clear and hold
module peak_tracker
   import spectrum_frame_sequencer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              valid,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] peak
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         peak <= '0;
      end else if (valid && (data > peak)) begin
         peak <= data;
      end
   end

endmodule

// File: rtl/spectrum_frame_sequencer.sv
// rtl/spectrum_frame_sequencer.sv - frame peak scan, adapter handshake and display bank swap
module spectrum_frame_sequencer
   import spectrum_frame_sequencer_pkg::*;
#(
   parameter int N_POINTS      = N_POINTS_DEF,
   parameter int DATA_W        = DATA_W_DEF,
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int ADAPT_TIMEOUT = ADAPT_TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fft_done_i,
   output logic [ADDR_W-1:0] scan_addr_o,
   input  logic [DATA_W-1:0] scan_data_i,
   output logic              adapt_start_o,
   output logic [DATA_W-1:0] max_value_o,
   input  logic              adapt_done_i,
   input  logic              vsync_i,
   output logic              bank_sel_o,
   output logic              buffer_free_o,
   output logic              busy_o,
   output logic              overrun_o,
   output logic              timeout_o
);

   localparam int TO_W = $clog2(ADAPT_TIMEOUT + 1);

   seq_state_e        state, state_nxt;
   logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
   logic              data_valid, data_valid_nxt;
   logic [ADDR_W-1:0] scan_addr_nxt;
   logic              adapt_start_nxt, buffer_free_nxt, bank_nxt;
   logic              busy_nxt, overrun_nxt, timeout_nxt, peak_clear;
   logic              scan_last, to_hit;

   assign scan_last = (scan_addr_o == ADDR_W'(N_POINTS - 1));
   assign to_hit    = (to_cnt == TO_W'(ADAPT_TIMEOUT - 1));

   // Every output is a flop; the output process only computes their next values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         to_cnt        <= '0;
         data_valid    <= 1'b0;
         scan_addr_o   <= '0;
         adapt_start_o <= 1'b0;
         buffer_free_o <= 1'b0;
         bank_sel_o    <= 1'b0;
         busy_o        <= 1'b0;
         overrun_o     <= 1'b0;
         timeout_o     <= 1'b0;
      end else begin
         state         <= state_nxt;
         to_cnt        <= to_cnt_nxt;
         data_valid    <= data_valid_nxt;
         scan_addr_o   <= scan_addr_nxt;
         adapt_start_o <= adapt_start_nxt;
         buffer_free_o <= buffer_free_nxt;
         bank_sel_o    <= bank_nxt;
         busy_o        <= busy_nxt;
         overrun_o     <= overrun_nxt;
         timeout_o     <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:       if (fft_done_i) state_nxt = ST_SCAN;
         ST_SCAN:       if (scan_last) state_nxt = ST_DRAIN;
         ST_DRAIN:      state_nxt = ST_START;
         ST_START:      state_nxt = ST_ADAPT_WAIT;
         // A late adapt_done on the final allowed cycle still wins over the timeout.
         ST_ADAPT_WAIT: begin
            if (adapt_done_i)  state_nxt = ST_SWAP_WAIT;
            else if (to_hit)   state_nxt = ST_IDLE;
         end
         ST_SWAP_WAIT:  if (vsync_i) state_nxt = ST_IDLE;
         default:       state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      scan_addr_nxt   = '0;
      if ((state == ST_SCAN) && (state_nxt == ST_SCAN)) begin
         scan_addr_nxt = scan_addr_o + ADDR_W'(1);
      end
      to_cnt_nxt      = '0;
      if ((state == ST_ADAPT_WAIT) && (state_nxt == ST_ADAPT_WAIT)) begin
         to_cnt_nxt = to_cnt + TO_W'(1);
      end
      // Read data lags the address by one cycle, so validity is the previous cycle's SCAN.
      data_valid_nxt  = (state == ST_SCAN);
      peak_clear      = (state == ST_IDLE) && fft_done_i;
      adapt_start_nxt = (state_nxt == ST_START);
      buffer_free_nxt = (state == ST_ADAPT_WAIT) && (state_nxt != ST_ADAPT_WAIT);
      bank_nxt        = bank_sel_o ^ ((state == ST_SWAP_WAIT) && vsync_i);
      busy_nxt        = (state_nxt != ST_IDLE);
      overrun_nxt     = overrun_o | (fft_done_i && (state != ST_IDLE));
      timeout_nxt     = timeout_o | ((state == ST_ADAPT_WAIT) && !adapt_done_i && to_hit);
   end

   peak_tracker #(
      .DATA_W (DATA_W)
   ) u_peak_tracker (
      .clk   (clk),
      .rst   (rst),
      .clear (peak_clear),
      .valid (data_valid),
      .data  (scan_data_i),
      .peak  (max_value_o)
   );

endmodule

// File: tb/tb_spectrum_frame_sequencer.sv
// tb/tb_spectrum_frame_sequencer.sv - self-checking bench for spectrum_frame_sequencer
module tb_spectrum_frame_sequencer;

   localparam int N  = 1024;
   localparam int DW = 64;
   localparam int AW = 10;
   localparam int TO = 2048;

   logic          clk;
   logic          rst;
   logic          fft_done_i;
   logic [AW-1:0] scan_addr_o;
   logic [DW-1:0] scan_data_i;
   logic          adapt_start_o;
   logic [DW-1:0] max_value_o;
   logic          adapt_done_i;
   logic          vsync_i;
   logic          bank_sel_o;
   logic          buffer_free_o;
   logic          busy_o;
   logic          overrun_o;
   logic          timeout_o;

   logic [DW-1:0] mem [N];
   int            tests = 0;
   int            fails = 0;
   logic          exp_bank = 1'b0;
   logic          exp_overrun = 1'b0;
   logic          exp_timeout = 1'b0;

   typedef struct {
      int            pattern;
      int            adapt_dly;
      int            vsync_dly;
      int            inject;
      logic [DW-1:0] exp_max;
   } vec_t;

   vec_t vecs [8];

   spectrum_frame_sequencer #(
      .N_POINTS      (N),
      .DATA_W        (DW),
      .ADDR_W        (AW),
      .ADAPT_TIMEOUT (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .fft_done_i    (fft_done_i),
      .scan_addr_o   (scan_addr_o),
      .scan_data_i   (scan_data_i),
      .adapt_start_o (adapt_start_o),
      .max_value_o   (max_value_o),
      .adapt_done_i  (adapt_done_i),
      .vsync_i       (vsync_i),
      .bank_sel_o    (bank_sel_o),
      .buffer_free_o (buffer_free_o),
      .busy_o        (busy_o),
      .overrun_o     (overrun_o),
      .timeout_o     (timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Input buffer with one-cycle read latency.
   always @(posedge clk) scan_data_i <= mem[scan_addr_o];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic fill(input int pattern);
      for (int k = 0; k < N; k++) begin
         case (pattern)
            0: mem[k] = DW'(k);
            1: mem[k] = (k == 512) ? 64'h8000_0000_0000_0000 : 64'd0;
            3: mem[k] = '1;
            4: mem[k] = {$urandom, $urandom};
            5: mem[k] = DW'(N - 1 - k);
            6: mem[k] = (k == N - 1) ? 64'hFFFF_0000_0000_0001 : DW'(k);
            7: mem[k] = (k == 0) ? 64'hDEAD_BEEF_0000_0000 : DW'(k);
            default: mem[k] = '0;
         endcase
      end
   endtask

   function automatic logic [DW-1:0] model_max();
      logic [DW-1:0] m = '0;
      for (int k = 0; k < N; k++) if (mem[k] > m) m = mem[k];
      return m;
   endfunction

   // Starts a frame and returns in the cycle adapt_start_o is expected high.
   task automatic run_scan(input bit inject);
      int err = 0;
      fft_done_i = 1'b1;
      tick();
      for (int k = 1; k <= N + 1; k++) begin
         if (scan_addr_o !== ((k <= N) ? AW'(k - 1) : AW'(0))) err++;
         if (adapt_start_o !== 1'b0 || busy_o !== 1'b1) err++;
         fft_done_i = inject && (k == 300);
         tick();
      end
      fft_done_i = 1'b0;
      if (inject) exp_overrun = 1'b1;
      check("scan_seq", 64'(err), 64'd0);
      check("adapt_start", 64'(adapt_start_o), 64'd1);
   endtask

   task automatic run_frame(input vec_t v);
      int err = 0;
      run_scan((v.inject & 1) != 0);
      check("max_value", max_value_o, v.exp_max);
      check("overrun_scan", 64'(overrun_o), 64'(exp_overrun));
      for (int i = 0; i < v.adapt_dly; i++) begin
         vsync_i = (i == 1);
         tick();
         if (adapt_start_o || buffer_free_o || !busy_o || max_value_o !== v.exp_max) err++;
      end
      vsync_i      = 1'b0;
      adapt_done_i = 1'b1;
      tick();
      adapt_done_i = 1'b0;
      check("adapt_wait", 64'(err), 64'd0);
      check("buffer_free", 64'(buffer_free_o), 64'd1);
      check("bank_hold", 64'(bank_sel_o), 64'(exp_bank));
      err = 0;
      for (int i = 1; i < v.vsync_dly; i++) begin
         adapt_done_i = (i == 1);
         tick();
         if (buffer_free_o || bank_sel_o !== exp_bank || !busy_o) err++;
      end
      adapt_done_i = 1'b0;
      vsync_i      = 1'b1;
      fft_done_i   = (v.inject & 2) != 0;
      tick();
      vsync_i    = 1'b0;
      fft_done_i = 1'b0;
      exp_bank   = ~exp_bank;
      if ((v.inject & 2) != 0) exp_overrun = 1'b1;
      check("swap_wait", 64'(err), 64'd0);
      check("bank_swap", 64'(bank_sel_o), 64'(exp_bank));
      check("idle_flags", 64'({busy_o, overrun_o, timeout_o}), 64'({1'b0, exp_overrun, exp_timeout}));
      tick();
      check("idle_after", 64'({busy_o, adapt_start_o, buffer_free_o}), 64'd0);
   endtask

   initial begin
      vec_t v;
      int   n;
      vecs[0] = '{1, 10, 5, 0, 64'h8000_0000_0000_0000};
      vecs[1] = '{0, 10, 5, 0, 64'd1023};
      vecs[2] = '{0, 1, 1, 1, 64'd1023};
      vecs[3] = '{2, 3, 2, 0, 64'd0};
      vecs[4] = '{3, TO, 1, 2, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[5] = '{5, 7, 3, 0, 64'd1023};
      vecs[6] = '{6, 4, 4, 0, 64'hFFFF_0000_0000_0001};
      vecs[7] = '{7, 5, 6, 0, 64'hDEAD_BEEF_0000_0000};

      rst = 1'b1; fft_done_i = 1'b0; adapt_done_i = 1'b0; vsync_i = 1'b0;
      fill(2);
      tick(); tick(); tick();
      rst = 1'b0;
      check("reset_state", 64'({scan_addr_o, adapt_start_o, bank_sel_o, buffer_free_o,
                                busy_o, overrun_o, timeout_o}), 64'd0);
      check("reset_max", max_value_o, 64'd0);
      tick();
      check("post_reset_pulses", 64'({adapt_start_o, buffer_free_o, busy_o}), 64'd0);

      for (int i = 0; i < 8; i++) begin
         fill(vecs[i].pattern);
         run_frame(vecs[i]);
      end

      for (int r = 0; r < 6; r++) begin
         fill(4);
         if (r % 2 == 1) for (int k = 0; k < N; k++) mem[k] = mem[k] >> $urandom_range(1, 40);
         v.pattern   = 4;
         v.adapt_dly = $urandom_range(1, 40);
         v.vsync_dly = $urandom_range(1, 20);
         v.inject    = $urandom_range(0, 3);
         v.exp_max   = model_max();
         run_frame(v);
      end

      // Adapter never answers.
      fill(0);
      run_scan(1'b0);
      check("timeout_max", max_value_o, 64'd1023);
      n = 0;
      while (!timeout_o && n < 3000) begin
         tick();
         n++;
      end
      exp_timeout = 1'b1;
      check("timeout_cycles", 64'(n), 64'(TO + 1));
      check("timeout_flags", 64'({timeout_o, buffer_free_o, busy_o, bank_sel_o}),
            64'({1'b1, 1'b1, 1'b0, exp_bank}));
      adapt_done_i = 1'b1;
      tick();
      adapt_done_i = 1'b0;
      check("late_adapt_done", 64'({buffer_free_o, busy_o, timeout_o}), 64'({1'b0, 1'b0, 1'b1}));

      // Reset in the middle of a scan, with fft_done_i held high alongside it.
      fill(4);
      fft_done_i = 1'b1;
      tick();
      fft_done_i = 1'b0;
      n = 0;
      while (scan_addr_o !== AW'(300) && n < 2000) begin
         tick();
         n++;
      end
      check("reach_addr_300", 64'(scan_addr_o), 64'd300);
      rst        = 1'b1;
      fft_done_i = 1'b1;
      tick();
      rst        = 1'b0;
      fft_done_i = 1'b0;
      exp_bank = 1'b0; exp_overrun = 1'b0; exp_timeout = 1'b0;
      check("midscan_reset", 64'({scan_addr_o, adapt_start_o, bank_sel_o, buffer_free_o,
                                  busy_o, overrun_o, timeout_o}), 64'd0);
      check("midscan_reset_max", max_value_o, 64'd0);
      tick();
      check("reset_dominates", 64'({busy_o, adapt_start_o, buffer_free_o}), 64'd0);
      fill(0);
      run_frame(vecs[1]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spectrum_frame_sequencer.md
SPECTRUM_FRAME_SEQUENCER -- requirements
Module: spectrum_frame_sequencer

Interface
REQ-001 SHALL have parameter N_POINTS, default 1024, number of magnitude words per frame.
REQ-002 SHALL have parameter DATA_W, default 64, magnitude word width.
REQ-003 SHALL have parameter ADDR_W, default 10, scan address width (2^ADDR_W = N_POINTS).
REQ-004 SHALL have parameter ADAPT_TIMEOUT, default 2048, max cycles waited for adapt_done_i.
REQ-005 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port fft_done_i  in  1  one-cycle pulse: new frame complete in the input buffer.
REQ-008 SHALL have port scan_addr_o  out  ADDR_W  input-buffer read address during the peak scan.
REQ-009 SHALL have port scan_data_i  in  DATA_W  input-buffer read data, valid one cycle after scan_addr_o.
REQ-010 SHALL have port adapt_start_o  out  1  one-cycle pulse starting the scaling adapter.
REQ-011 SHALL have port max_value_o  out  DATA_W  frame peak, stable from the adapt_start_o cycle until the next scan starts.
REQ-012 SHALL have port adapt_done_i  in  1  one-cycle pulse from the adapter: scaled frame written.
REQ-013 SHALL have port vsync_i  in  1  one-cycle pulse at display frame boundary.
REQ-014 SHALL have port bank_sel_o  out  1  display bank read by VGA; the adapter writes bank ~bank_sel_o.
REQ-015 SHALL have port buffer_free_o  out  1  one-cycle pulse: input buffer may be overwritten by the FFT.
REQ-016 SHALL have ports busy_o  out  1  (state != IDLE); overrun_o  out  1  sticky dropped-frame flag; timeout_o  out  1  sticky adapter-timeout flag.

Function
REQ-017 SHALL implement states IDLE, SCAN, DRAIN, START, ADAPT_WAIT, SWAP_WAIT.
REQ-018 IDLE: fft_done_i=1 -> SCAN next cycle; peak register cleared to 0 on that transition.
REQ-019 SCAN: scan_addr_o = 0 on first SCAN cycle, +1 per cycle; after address N_POINTS-1 -> DRAIN.
REQ-020 Peak update: each cycle where data is valid (SCAN cycles 2..N_POINTS, DRAIN), if scan_data_i > peak (unsigned) peak <= scan_data_i.
REQ-021 DRAIN (one cycle) -> START; START asserts adapt_start_o for exactly one cycle, max_value_o = peak, -> ADAPT_WAIT.
REQ-022 Latency: fft_done_i at edge T -> addresses 0..N_POINTS-1 on T+1..T+N_POINTS, adapt_start_o high in cycle T+N_POINTS+2.
REQ-023 ADAPT_WAIT: adapt_done_i=1 -> buffer_free_o pulse same cycle as transition, -> SWAP_WAIT; timeout counter counts cycles in ADAPT_WAIT.
REQ-024 Timeout counter reaching ADAPT_TIMEOUT without adapt_done_i -> timeout_o <= 1, buffer_free_o pulse, -> IDLE, no bank swap.
REQ-025 SWAP_WAIT: vsync_i=1 -> bank_sel_o toggles, -> IDLE; vsync_i outside SWAP_WAIT ignored.
REQ-026 fft_done_i in any state other than IDLE -> frame dropped, overrun_o <= 1, state unaffected.
REQ-027 fft_done_i in the same cycle as the SWAP_WAIT->IDLE transition -> counted as overrun (not queued).
REQ-028 adapt_done_i outside ADAPT_WAIT ignored; scan_addr_o = 0 outside SCAN.
REQ-029 All-zero frame -> max_value_o = 0; sequence otherwise unchanged.
REQ-030 All outputs registered; no combinational path from any input to any output.

Reset
REQ-031 rst=1 at any edge, including mid-scan or mid-adapt -> state IDLE, peak 0, timeout counter 0, scan_addr_o 0, max_value_o 0, bank_sel_o 0, adapt_start_o/buffer_free_o 0, overrun_o/timeout_o 0, busy_o 0.
REQ-032 Reset SHALL dominate all inputs in the same cycle; no pulse output asserted in the cycle after reset release.

Structure
REQ-033 N_POINTS, DATA_W, ADDR_W defaults and the state encoding SHALL live in the shared spectrum constants package/header used by the FFT and VGA blocks.
REQ-034 Peak tracking (clear, compare, hold) SHALL be a sub-module named peak_tracker; FSM, counters and flags stay in the top.

Verification
REQ-035 Frame with word k = k, fft_done at T -> addresses 0..1023 on T+1..T+1024, adapt_start_o at T+1026, max_value_o = 1023.
REQ-036 Frame all zero except word 512 = 64'h8000_0000_0000_0000 -> max_value_o = 64'h8000_0000_0000_0000; adapt_done 10 cycles later -> buffer_free_o same cycle; vsync 5 cycles later -> bank_sel_o 0->1.
REQ-037 Second fft_done during SCAN -> overrun_o = 1, first frame completes normally, no second adapt_start_o.
REQ-038 No adapt_done_i after adapt_start_o -> timeout_o = 1 after 2048 ADAPT_WAIT cycles, buffer_free_o pulse, bank_sel_o unchanged, busy_o = 0.
REQ-039 rst pulsed at scan address 300 -> all outputs reset values next cycle; fresh fft_done -> full sequence with peak from new frame only.
